// File: rtl/gt_cmp_exerciser.sv
// Exhaustive self-test engine for a W-bit greater-than comparator: sweeps every
// (i0, i1) pair, checks gt against an internal golden model and reports results.
module gt_cmp_exerciser #(
    parameter int W          = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [W-1:0]     i0,
    output logic [W-1:0]     i1,
    input  logic             gt,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*W:0]     err_count,
    output logic             fail_valid,
    output logic [W-1:0]     fail_i0,
    output logic [W-1:0]     fail_i1
);

    localparam int VEC_W = 2 * W;
    localparam int ERR_W = 2 * W + 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [VEC_W-1:0] VEC_ZERO    = {VEC_W{1'b0}};
    localparam logic [VEC_W-1:0] VEC_ONE     = VEC_W'(1);
    localparam logic [VEC_W-1:0] VEC_ALL     = {VEC_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [W-1:0]     OP_ZERO     = {W{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Reference model: unsigned greater-than.
    function automatic logic golden_gt(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b);
    endfunction

    state_t           state_r, state_s;
    logic [VEC_W-1:0] vec_r, vec_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             pass_r, pass_s;
    logic [ERR_W-1:0] err_r, err_s;
    logic             fail_valid_r, fail_valid_s;
    logic [W-1:0]     fail_i0_r, fail_i0_s;
    logic [W-1:0]     fail_i1_r, fail_i1_s;
    logic             mismatch_s;

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_s      = state_r;
        vec_s        = vec_r;
        cnt_s        = cnt_r;
        busy_s       = busy_r;
        done_s       = done_r;
        pass_s       = pass_r;
        err_s        = err_r;
        fail_valid_s = fail_valid_r;
        fail_i0_s    = fail_i0_r;
        fail_i1_s    = fail_i1_r;
        mismatch_s   = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                // A restart from DONE behaves exactly like a start from IDLE.
                if (start) begin
                    state_s      = SETTLE;
                    vec_s        = VEC_ZERO;
                    cnt_s        = CNT_ZERO;
                    busy_s       = 1'b1;
                    done_s       = 1'b0;
                    pass_s       = 1'b0;
                    err_s        = ERR_ZERO;
                    fail_valid_s = 1'b0;
                    fail_i0_s    = OP_ZERO;
                    fail_i1_s    = OP_ZERO;
                end else begin
                    state_s = state_r;
                end
            end
            SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s = CHECK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            CHECK: begin
                mismatch_s = (gt != golden_gt(vec_r[VEC_W-1:W], vec_r[W-1:0]));
                if (mismatch_s) begin
                    err_s = err_r + ERR_ONE;
                    // Only the first failing vector is recorded.
                    if (!fail_valid_r) begin
                        fail_valid_s = 1'b1;
                        fail_i0_s    = vec_r[VEC_W-1:W];
                        fail_i1_s    = vec_r[W-1:0];
                    end else begin
                        fail_valid_s = fail_valid_r;
                    end
                end else begin
                    err_s = err_r;
                end
                if (vec_r == VEC_ALL) begin
                    state_s = DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_s == ERR_ZERO);
                end else begin
                    state_s = SETTLE;
                    vec_s   = vec_r + VEC_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
                pass_s  = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset that aborts any sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            vec_r        <= VEC_ZERO;
            cnt_r        <= CNT_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_r        <= ERR_ZERO;
            fail_valid_r <= 1'b0;
            fail_i0_r    <= OP_ZERO;
            fail_i1_r    <= OP_ZERO;
        end else begin
            state_r      <= state_s;
            vec_r        <= vec_s;
            cnt_r        <= cnt_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
            err_r        <= err_s;
            fail_valid_r <= fail_valid_s;
            fail_i0_r    <= fail_i0_s;
            fail_i1_r    <= fail_i1_s;
        end
    end

    assign i0         = vec_r[VEC_W-1:W];
    assign i1         = vec_r[W-1:0];
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_count  = err_r;
    assign fail_valid = fail_valid_r;
    assign fail_i0    = fail_i0_r;
    assign fail_i1    = fail_i1_r;

endmodule

// File: tb/tb_gt_cmp_exerciser.sv
// Directed bench: two exerciser instances (W=2/SETTLE=1 and W=3/SETTLE=2) driving
// a bench-side comparator that is golden, stuck-at-0 or reversed.
module tb_gt_cmp_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A: W=2, SETTLE_CYC=1
    logic       reset_a, start_a, gt_a;
    logic [1:0] i0_a, i1_a, fi0_a, fi1_a;
    logic       busy_a, done_a, pass_a, fv_a;
    logic [4:0] err_a;
    int         mode_a;

    // Instance B: W=3, SETTLE_CYC=2
    logic       reset_b, start_b, gt_b;
    logic [2:0] i0_b, i1_b, fi0_b, fi1_b;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [6:0] err_b;
    int         mode_b;

    gt_cmp_exerciser #(.W(2), .SETTLE_CYC(1)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .i0(i0_a), .i1(i1_a), .gt(gt_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fv_a), .fail_i0(fi0_a), .fail_i1(fi1_a)
    );

    gt_cmp_exerciser #(.W(3), .SETTLE_CYC(2)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .i0(i0_b), .i1(i1_b), .gt(gt_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fv_b), .fail_i0(fi0_b), .fail_i1(fi1_b)
    );

    // Comparator under test: 0 = golden, 1 = stuck at 0, 2 = computes i0 < i1
    always_comb begin
        case (mode_a)
            0:       gt_a = (i0_a > i1_a);
            1:       gt_a = 1'b0;
            default: gt_a = (i0_a < i1_a);
        endcase
        case (mode_b)
            0:       gt_b = (i0_b > i1_b);
            1:       gt_b = 1'b0;
            default: gt_b = (i0_b < i1_b);
        endcase
    end

    // Pulse start on instance A for one edge; returns just after that edge.
    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    // Counts edges after the start edge until done on instance A (limit+1 on timeout).
    task automatic wait_done_a(input int limit, output int n);
        n = limit + 1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        mode_a = 0; mode_b = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({i0_a, i1_a, busy_a, done_a, pass_a, err_a, fv_a, fi0_a, fi1_a} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_a outputs=%b required=0",
                     {i0_a, i1_a, busy_a, done_a, pass_a, err_a, fv_a, fi0_a, fi1_a});
        end
        vectors++;
        if ({i0_b, i1_b, busy_b, done_b, pass_b, err_b, fv_b, fi0_b, fi1_b} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_b outputs=%b required=0",
                     {i0_b, i1_b, busy_b, done_b, pass_b, err_b, fv_b, fi0_b, fi1_b});
        end
        @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;
    endtask

    task automatic test_golden();
        int n;
        mode_a = 0;
        pulse_start_a();
        vectors++;
        if (busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL golden_busy got=%b required=1", busy_a);
        end
        wait_done_a(400, n);
        vectors++;
        if (n != 32) begin
            miscompares++;
            $display("FAIL golden_done_edge got=%0d required=32", n);
        end
        vectors++;
        if ({pass_a, err_a, fv_a, busy_a} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL golden_result pass=%b err=%0d fv=%b busy=%b required pass=1 err=0 fv=0 busy=0",
                     pass_a, err_a, fv_a, busy_a);
        end
        vectors++;
        if ({i0_a, i1_a} !== 4'b1111) begin
            miscompares++;
            $display("FAIL golden_last_vector got=%b required=1111", {i0_a, i1_a});
        end
    endtask

    task automatic test_stuck0();
        int n;
        mode_a = 1;
        pulse_start_a();
        vectors++;
        if ({done_a, err_a, fv_a} !== {1'b0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL stuck0_restart_clear done=%b err=%0d fv=%b required 0/0/0",
                     done_a, err_a, fv_a);
        end
        wait_done_a(400, n);
        vectors++;
        if (n != 32) begin
            miscompares++;
            $display("FAIL stuck0_done_edge got=%0d required=32", n);
        end
        vectors++;
        if ({err_a, pass_a, fv_a, fi0_a, fi1_a} !== {5'd6, 1'b0, 1'b1, 2'd1, 2'd0}) begin
            miscompares++;
            $display("FAIL stuck0_result err=%0d pass=%b fv=%b fi0=%0d fi1=%0d required 6/0/1/1/0",
                     err_a, pass_a, fv_a, fi0_a, fi1_a);
        end
    endtask

    task automatic test_lt();
        int n;
        mode_a = 2;
        pulse_start_a();
        wait_done_a(400, n);
        vectors++;
        if ({err_a, pass_a, fv_a, fi0_a, fi1_a} !== {5'd12, 1'b0, 1'b1, 2'd0, 2'd1}) begin
            miscompares++;
            $display("FAIL lt_result err=%0d pass=%b fv=%b fi0=%0d fi1=%0d required 12/0/1/0/1",
                     err_a, pass_a, fv_a, fi0_a, fi1_a);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        mode_a = 1;
        pulse_start_a();
        n = 401;
        for (int k = 1; k <= 400; k++) begin
            if (k == 10) start_a = 1'b1;
            @(posedge clk);
            #1;
            start_a = 1'b0;
            if (done_a) begin
                n = k;
                break;
            end
        end
        vectors++;
        if (n != 32) begin
            miscompares++;
            $display("FAIL ignore_start_done_edge got=%0d required=32", n);
        end
        vectors++;
        if ({err_a, fv_a, fi0_a, fi1_a} !== {5'd6, 1'b1, 2'd1, 2'd0}) begin
            miscompares++;
            $display("FAIL ignore_start_result err=%0d fv=%b fi0=%0d fi1=%0d required 6/1/1/0",
                     err_a, fv_a, fi0_a, fi1_a);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        mode_a = 1;
        pulse_start_a();
        for (int k = 1; k <= 15; k++) begin
            if (k == 15) reset_a = 1'b1;
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({i0_a, i1_a, busy_a, done_a, pass_a, err_a, fv_a, fi0_a, fi1_a} !== 18'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got=%b required=0",
                     {i0_a, i1_a, busy_a, done_a, pass_a, err_a, fv_a, fi0_a, fi1_a});
        end
        reset_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({i0_a, i1_a, busy_a, done_a} !== 6'd0) begin
            miscompares++;
            $display("FAIL mid_reset_idle got=%b required=0", {i0_a, i1_a, busy_a, done_a});
        end
        mode_a = 0;
        pulse_start_a();
        wait_done_a(400, n);
        vectors++;
        if (n != 32 || pass_a !== 1'b1 || err_a !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_reset_rerun edge=%0d pass=%b err=%0d required 32/1/0", n, pass_a, err_a);
        end
    endtask

    task automatic test_w3();
        int n;
        mode_b = 1;
        for (int run = 0; run < 2; run++) begin
            @(negedge clk);
            start_b = 1'b1;
            @(posedge clk);
            #1;
            start_b = 1'b0;
            if (run == 1) begin
                vectors++;
                if ({busy_b, done_b, err_b, fv_b, fi0_b, fi1_b} !== {1'b1, 1'b0, 7'd0, 1'b0, 3'd0, 3'd0}) begin
                    miscompares++;
                    $display("FAIL w3_restart_clear busy=%b done=%b err=%0d fv=%b required 1/0/0/0",
                             busy_b, done_b, err_b, fv_b);
                end
            end
            n = 1001;
            for (int k = 1; k <= 1000; k++) begin
                @(posedge clk);
                #1;
                if (done_b) begin
                    n = k;
                    break;
                end
            end
            vectors++;
            if (n != 192) begin
                miscompares++;
                $display("FAIL w3_done_edge run=%0d got=%0d required=192", run, n);
            end
            vectors++;
            if ({err_b, pass_b, fv_b, fi0_b, fi1_b} !== {7'd28, 1'b0, 1'b1, 3'd1, 3'd0}) begin
                miscompares++;
                $display("FAIL w3_result run=%0d err=%0d pass=%b fv=%b fi0=%0d fi1=%0d required 28/0/1/1/0",
                         run, err_b, pass_b, fv_b, fi0_b, fi1_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_stuck0();
        test_lt();
        test_ignore_start();
        test_mid_reset();
        test_w3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gt_cmp_exerciser.md
Name: gt_cmp_exerciser

Overview:
- Hardware-side exhaustive stimulus/response engine for the W-bit greater-than comparator. It is the driving end of the comparator's i0/i1/gt interface.
- Sweeps every (i0, i1) pair into the comparator and samples its gt output after a settle interval. Each sample is checked against an internal golden i0 > i1.
- Reports pass/fail, an error count and the first failing vector.
- Used for on-board self-test of the comparator; results go to LEDs or a seven-segment display.

Parameters:
- W, 2, operand width of the comparator under test (W >= 1).
- SETTLE_CYC, 1, cycles each vector is held before gt is sampled (SETTLE_CYC >= 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- i0  out  W  operand A driven to the comparator (registered).
- i1  out  W  operand B driven to the comparator (registered).
- gt  in  1  comparator result for the current i0/i1.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; results valid. Held until the next start or reset.
- pass  out  1  1 when done and err_count == 0; 0 otherwise.
- err_count  out  2W+1  number of mismatching vectors in the last sweep.
- fail_valid  out  1  at least one mismatch has been recorded.
- fail_i0  out  W  i0 of the first mismatching vector.
- fail_i1  out  W  i1 of the first mismatching vector.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-high.
  - While reset is high at an edge, the state goes to IDLE and every output is 0: i0, i1, busy, done, pass, err_count, fail_valid, fail_i0, fail_i1.
  - Reset mid-sweep aborts immediately; no partial results are retained.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 clears err_count, fail_valid, fail_i0, fail_i1, done and pass.
  - It loads i0=0, i1=0, loads the settle counter with 0, and moves to SETTLE.
- SETTLE:
  - busy=1; i0/i1 are held.
  - The state is occupied for exactly SETTLE_CYC cycles, then moves to CHECK.
- CHECK:
  - busy=1. The single edge leaving CHECK compares gt with the expected value (i0 > i1, unsigned).
  - On mismatch: err_count increments. If fail_valid=0, fail_i0/fail_i1 capture the current i0/i1 and fail_valid goes to 1.
  - Later mismatches never overwrite the first-fail registers.
  - If {i0,i1} is all ones, the next state is DONE. Otherwise {i0,i1} increments as one 2W-bit counter (i1 = LSBs, so i1 is the inner loop) and the next state is SETTLE.
- DONE:
  - busy=0, done=1, pass=(err_count==0). i0/i1 hold the last vector.
  - start=1 restarts exactly as from IDLE, clearing results in the same edge.
- Timing:
  - start is ignored in SETTLE and CHECK.
  - Vectors: 2^(2W). Each vector takes SETTLE_CYC+1 cycles.
  - done rises 2^(2W)*(SETTLE_CYC+1) edges after the start edge (32 for the defaults).
- err_count width 2W+1 holds the maximum count of 2^(2W), so it never wraps.
- gt is sampled only in CHECK; its value in other states has no effect.

Test Plan:
- Golden comparator, W=2, SETTLE_CYC=1, one start pulse:
  - busy rises the next cycle; done rises exactly 32 edges after start.
  - pass=1, err_count=0, fail_valid=0.
- gt stuck at 0:
  - err_count=6, pass=0, fail_valid=1, fail_i0=1, fail_i1=0.
- gt computed as i0 < i1:
  - err_count=12, first fail i0=0, i1=1.
- start pulsed again at cycle 10 of a sweep:
  - Ignored; done still at edge 32 with unchanged results.
- Reset asserted at cycle 15 mid-sweep:
  - The next cycle all outputs are 0 and the state is IDLE.
  - A later start completes normally with pass=1.
- W=3, SETTLE_CYC=2, gt stuck at 0:
  - done at edge 192, err_count=28, first fail i0=1, i1=0.
  - A start issued in DONE clears the results and reruns the sweep.
